// File: rtl/icache_refill_pkg.sv
// Shared types and helpers for the icache refill line builder.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    function automatic int beats_per_line(input int line_width, input int beat_width);
        return line_width / beat_width;
    endfunction

endpackage

// File: rtl/icache_refill_beat_buf.sv
// Line assembly buffer: one register per beat slot plus a saturating slot counter.
module icache_refill_beat_buf #(
    parameter int BeatWidth    = 32,
    parameter int BeatsPerLine = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              write,
    input  logic [BeatWidth-1:0]              data,
    output logic [$clog2(BeatsPerLine)-1:0]   count,
    output logic [BeatsPerLine*BeatWidth-1:0] line
);

    localparam int CountWidth = $clog2(BeatsPerLine);
    localparam logic [CountWidth-1:0] LastSlot = CountWidth'(BeatsPerLine - 1);

    logic [BeatWidth-1:0] slots [BeatsPerLine];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < BeatsPerLine; i++) slots[i] <= '0;
        end else if (clear) begin
            count <= '0;
            for (int i = 0; i < BeatsPerLine; i++) slots[i] <= '0;
        end else if (write) begin
            slots[count] <= data;
            // Saturate so a stray extra beat can never land back in slot 0.
            if (count != LastSlot) count <= count + 1'b1;
        end
    end

    for (genvar g = 0; g < BeatsPerLine; g++) begin : g_flatten
        assign line[g*BeatWidth +: BeatWidth] = slots[g];
    end

endmodule

// File: rtl/icache_refill_line_builder.sv
// Collects refill beats into a full cache line and issues one full-line SRAM write,
// reporting completion or error per line to the refill controller.
module icache_refill_line_builder
    import icache_refill_pkg::*;
#(
    parameter int NumWords  = 256,
    parameter int LineWidth = 128,
    parameter int BeatWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          refill_req_valid_i,
    output logic                          refill_req_ready_o,
    input  logic [$clog2(NumWords)-1:0]   refill_req_addr_i,
    input  logic                          beat_valid_i,
    output logic                          beat_ready_o,
    input  logic [BeatWidth-1:0]          beat_data_i,
    input  logic                          beat_last_i,
    input  logic                          beat_err_i,
    output logic                          sram_req_o,
    input  logic                          sram_gnt_i,
    output logic                          sram_we_o,
    output logic [$clog2(NumWords)-1:0]   sram_addr_o,
    output logic [LineWidth-1:0]          sram_wdata_o,
    output logic [LineWidth/8-1:0]        sram_be_o,
    output logic                          done_valid_o,
    output logic                          done_err_o,
    output logic [$clog2(NumWords)-1:0]   done_addr_o
);

    localparam int AddrWidth    = $clog2(NumWords);
    localparam int BeatsPerLine = beats_per_line(LineWidth, BeatWidth);
    localparam int CountWidth   = $clog2(BeatsPerLine);
    localparam logic [CountWidth-1:0] FinalSlot = CountWidth'(BeatsPerLine - 1);

    if (LineWidth % BeatWidth != 0) begin : g_bad_ratio
        $error("LineWidth must be a whole multiple of BeatWidth");
    end
    if (BeatsPerLine < 2) begin : g_too_few_beats
        $error("a line must span at least two beats");
    end

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic                   err_q, err_d;
    logic                   done_valid_q, done_err_q;
    logic [AddrWidth-1:0]   done_addr_q;

    logic                   accept;
    logic                   exit_done, exit_err;
    logic                   buf_clear, buf_write;
    logic                   final_beat;
    logic [CountWidth-1:0]  count;
    logic [LineWidth-1:0]   line;

    icache_refill_beat_buf #(
        .BeatWidth   (BeatWidth),
        .BeatsPerLine(BeatsPerLine)
    ) u_beat_buf (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(buf_clear),
        .write(buf_write),
        .data (beat_data_i),
        .count(count),
        .line (line)
    );

    assign final_beat = (count == FinalSlot);

    always_comb begin
        state_d            = state_q;
        err_d              = err_q;
        accept             = 1'b0;
        exit_done          = 1'b0;
        exit_err           = 1'b0;
        buf_clear          = 1'b0;
        buf_write          = 1'b0;
        refill_req_ready_o = 1'b0;
        beat_ready_o       = 1'b0;
        sram_req_o         = 1'b0;
        case (state_q)
            IDLE: begin
                refill_req_ready_o = 1'b1;
                if (refill_req_valid_i) begin
                    accept    = 1'b1;
                    buf_clear = 1'b1;
                    err_d     = 1'b0;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                beat_ready_o = 1'b1;
                if (beat_valid_i) begin
                    buf_write = 1'b1;
                    // A line is good only if last arrives exactly on the final slot.
                    err_d = err_q | beat_err_i | (final_beat ^ beat_last_i);
                    if (beat_last_i || final_beat) begin
                        if (err_d) begin
                            exit_done = 1'b1;
                            exit_err  = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                sram_req_o = 1'b1;
                if (sram_gnt_i) begin
                    exit_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            done_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            done_valid_q <= exit_done;
            done_err_q   <= exit_err;
            if (accept)    addr_q      <= refill_req_addr_i;
            if (exit_done) done_addr_q <= addr_q;
        end
    end

    assign sram_we_o    = sram_req_o;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = line;
    assign sram_be_o    = {(LineWidth/8){sram_req_o}};
    assign done_valid_o = done_valid_q;
    assign done_err_o   = done_err_q;
    assign done_addr_o  = done_addr_q;

endmodule

// File: tb/tb_icache_refill_line_builder.sv
// Self-checking bench for icache_refill_line_builder with a line-level reference model.
module tb_icache_refill_line_builder;

    localparam int AW  = 8;
    localparam int LW  = 128;
    localparam int BW  = 32;
    localparam int BPL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          beat_valid = 1'b0;
    logic          beat_ready;
    logic [BW-1:0] beat_data = '0;
    logic          beat_last = 1'b0;
    logic          beat_err = 1'b0;
    logic          sram_req;
    logic          sram_gnt = 1'b0;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [LW-1:0] sram_wdata;
    logic [LW/8-1:0] sram_be;
    logic          done_valid;
    logic          done_err;
    logic [AW-1:0] done_addr;

    icache_refill_line_builder dut (
        .clk_i(clk), .rst_i(rst),
        .refill_req_valid_i(req_valid), .refill_req_ready_o(req_ready), .refill_req_addr_i(req_addr),
        .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_data_i(beat_data),
        .beat_last_i(beat_last), .beat_err_i(beat_err),
        .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
        .done_valid_o(done_valid), .done_err_o(done_err), .done_addr_o(done_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [LW/8-1:0] be;
        logic          we;
    } wr_t;
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          err;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    bit  req_seen = 1'b0;

    // Observed SRAM writes and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (!rst && sram_req) req_seen = 1'b1;
        if (!rst && sram_req && sram_gnt) begin
            w.cyc = cyc; w.addr = sram_addr; w.data = sram_wdata; w.be = sram_be; w.we = sram_we;
            wr_q.push_back(w);
        end
        if (!rst && done_valid) begin
            d.cyc = cyc; d.addr = done_addr; d.err = done_err;
            dn_q.push_back(d);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef logic [BW-1:0] beat_arr_t [BPL];
    typedef logic          flag_arr_t [BPL];

    // Line-level rule: beats up to the first last (or BPL beats) fill the line from
    // the LSBs; the line is good only with no bus error and last exactly on beat BPL-1.
    function automatic void model(input beat_arr_t d, input flag_arr_t l, input flag_arr_t e,
                                  output int n, output logic xerr, output logic [LW-1:0] w);
        n = BPL; xerr = 1'b0; w = '0;
        for (int i = 0; i < BPL; i++) if (l[i]) begin n = i + 1; break; end
        for (int i = 0; i < n; i++) begin
            w = w | (LW'(d[i]) << (BW * i));
            xerr = xerr | e[i];
        end
        if (n != BPL || !l[BPL-1]) xerr = 1'b1;
    endfunction

    task automatic do_req(input logic [AW-1:0] a, output int acc);
        req_valid = 1'b1; req_addr = a; acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic l, input logic e, output int acc);
        beat_valid = 1'b1; beat_data = d; beat_last = l; beat_err = e; acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beat_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        beat_valid = 1'b0; beat_last = 1'b0; beat_err = 1'b0;
    endtask

    task automatic send_line(input logic [AW-1:0] a, input beat_arr_t d, input flag_arr_t l,
                             input flag_arr_t e, input int n, output int last_acc);
        int acc;
        do_req(a, acc);
        last_acc = -1;
        for (int i = 0; i < n; i++) send_beat(d[i], l[i], e[i], last_acc);
    endtask

    task automatic clear_obs();
        wr_q.delete(); dn_q.delete(); req_seen = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({beat_ready, sram_req, sram_we, sram_be} !== '0) begin n_fail++; $display("FAIL reset_ctrl_outs: got %b/%b/%b/%h want 0", beat_ready, sram_req, sram_we, sram_be); end
        n_cmp++; if ({sram_addr, sram_wdata} !== '0) begin n_fail++; $display("FAIL reset_sram_data: got %h/%h want 0", sram_addr, sram_wdata); end
        n_cmp++; if ({done_valid, done_err, done_addr} !== '0) begin n_fail++; $display("FAIL reset_done: got %b/%b/%h want 0", done_valid, done_err, done_addr); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req_ready, beat_ready} !== 2'b10) begin n_fail++; $display("FAIL post_reset_idle: got %b want 10", {req_ready, beat_ready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_clean_line();
        beat_arr_t d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        flag_arr_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        flag_arr_t e = '{default: 1'b0};
        int last_acc;
        clear_obs();
        sram_gnt = 1'b1;
        beat_valid = 1'b1; beat_data = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL idle_beat_ready: got %b want 0", beat_ready); end
        @(posedge clk); #1 beat_valid = 1'b0;
        send_line(8'h2A, d, l, e, 4, last_acc);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL clean_write_count: got %0d want 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            n_cmp++; if (wr_q[0].addr !== 8'h2A) begin n_fail++; $display("FAIL clean_addr: got %h want 2a", wr_q[0].addr); end
            n_cmp++; if (wr_q[0].data !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL clean_wdata: got %h", wr_q[0].data); end
            n_cmp++; if ({wr_q[0].we, wr_q[0].be} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL clean_we_be: got %b/%h want 1/ffff", wr_q[0].we, wr_q[0].be); end
            n_cmp++; if (wr_q[0].cyc !== last_acc + 1) begin n_fail++; $display("FAIL clean_req_latency: got %0d want %0d", wr_q[0].cyc, last_acc + 1); end
        end
        n_cmp++; if (dn_q.size() !== 1) begin n_fail++; $display("FAIL clean_done_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_cmp++; if ({dn_q[0].err, dn_q[0].addr} !== {1'b0, 8'h2A}) begin n_fail++; $display("FAIL clean_done: got %b/%h want 0/2a", dn_q[0].err, dn_q[0].addr); end
            n_cmp++; if (dn_q[0].cyc !== last_acc + 2) begin n_fail++; $display("FAIL clean_done_latency: got %0d want %0d", dn_q[0].cyc, last_acc + 2); end
        end
    endtask

    task automatic test_grant_stall();
        beat_arr_t d;
        flag_arr_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        flag_arr_t e = '{default: 1'b0};
        logic [LW-1:0] w;
        logic xerr;
        int n, last_acc;
        for (int i = 0; i < BPL; i++) d[i] = $urandom;
        model(d, l, e, n, xerr, w);
        clear_obs();
        sram_gnt = 1'b0;
        send_line(8'h13, d, l, e, n, last_acc);
        beat_valid = 1'b1; beat_data = $urandom;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if ({sram_req, sram_addr, sram_wdata, sram_be, beat_ready} !== {1'b1, 8'h13, w, 16'hFFFF, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h/%h/%b want 1/13/%h/0", k, sram_req, sram_addr, sram_wdata, beat_ready, w);
            end
            @(posedge clk); #1;
            if (k == 4) sram_gnt = 1'b1;
            if (k == 5) sram_gnt = 1'b0;
        end
        beat_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL stall_write_count: got %0d want 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            n_cmp++; if (wr_q[0].cyc !== last_acc + 6) begin n_fail++; $display("FAIL stall_write_cycle: got %0d want %0d", wr_q[0].cyc, last_acc + 6); end
        end
        n_cmp++; if (dn_q.size() !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_cmp++; if ({dn_q[0].cyc, dn_q[0].err} !== {last_acc + 7, 1'b0}) begin n_fail++; $display("FAIL stall_done: got %0d/%b want %0d/0", dn_q[0].cyc, dn_q[0].err, last_acc + 7); end
        end
    endtask

    task automatic test_beat_err();
        beat_arr_t d;
        flag_arr_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        flag_arr_t e = '{1'b0, 1'b1, 1'b0, 1'b0};
        int last_acc;
        for (int i = 0; i < BPL; i++) d[i] = $urandom;
        clear_obs();
        sram_gnt = 1'b1;
        send_line(8'h2A, d, l, e, 4, last_acc);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if ({req_seen, wr_q.size()} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL err_no_write: got req_seen=%b writes=%0d want 0/0", req_seen, wr_q.size()); end
        n_cmp++; if (dn_q.size() !== 1) begin n_fail++; $display("FAIL err_done_count: got %0d want 1", dn_q.size()); end
        if (dn_q.size() > 0) begin
            n_cmp++; if ({dn_q[0].err, dn_q[0].addr} !== {1'b1, 8'h2A}) begin n_fail++; $display("FAIL err_done: got %b/%h want 1/2a", dn_q[0].err, dn_q[0].addr); end
            n_cmp++; if (dn_q[0].cyc !== last_acc + 1) begin n_fail++; $display("FAIL err_done_cycle: got %0d want %0d", dn_q[0].cyc, last_acc + 1); end
        end
    endtask

    task automatic test_early_and_missing_last();
        beat_arr_t d;
        flag_arr_t l_early = '{1'b0, 1'b0, 1'b1, 1'b0};
        flag_arr_t l_none  = '{default: 1'b0};
        flag_arr_t e = '{default: 1'b0};
        int last_acc;
        for (int i = 0; i < BPL; i++) d[i] = $urandom;
        clear_obs();
        sram_gnt = 1'b1;
        send_line(8'h30, d, l_early, e, 3, last_acc);
        beat_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL early_last_stops_collect: got %b want 0", beat_ready); end
        @(posedge clk); #1 beat_valid = 1'b0;
        send_line(8'h31, d, l_none, e, 4, last_acc);
        beat_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL final_beat_stops_collect: got %b want 0", beat_ready); end
        @(posedge clk); #1 beat_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({req_seen, wr_q.size()} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL last_err_no_write: got req_seen=%b writes=%0d want 0/0", req_seen, wr_q.size()); end
        n_cmp++; if (dn_q.size() !== 2) begin n_fail++; $display("FAIL last_err_done_count: got %0d want 2", dn_q.size()); end
        if (dn_q.size() > 1) begin
            n_cmp++; if ({dn_q[0].err, dn_q[0].addr, dn_q[1].err, dn_q[1].addr} !== {1'b1, 8'h30, 1'b1, 8'h31}) begin
                n_fail++; $display("FAIL last_err_dones: got %b/%h %b/%h want 1/30 1/31", dn_q[0].err, dn_q[0].addr, dn_q[1].err, dn_q[1].addr);
            end
        end
    endtask

    task automatic test_reset_mid_collect();
        beat_arr_t d;
        flag_arr_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        flag_arr_t e = '{default: 1'b0};
        logic [LW-1:0] w;
        logic xerr;
        int n, acc, last_acc;
        for (int i = 0; i < BPL; i++) d[i] = $urandom;
        clear_obs();
        sram_gnt = 1'b1;
        do_req(8'h2A, acc);
        send_beat(32'hAAAA0000, 1'b0, 1'b0, acc);
        send_beat(32'hBBBB1111, 1'b0, 1'b0, acc);
        rst = 1'b1;
        #2;
        n_cmp++; if ({sram_req, done_valid, beat_ready, req_ready, sram_addr, sram_wdata} !== {4'b0001, 8'h00, 128'h0}) begin
            n_fail++; $display("FAIL midreset_outs: got req=%b dv=%b br=%b rr=%b addr=%h wd=%h", sram_req, done_valid, beat_ready, req_ready, sram_addr, sram_wdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
        n_cmp++; if (wr_q.size() + dn_q.size() !== 0) begin n_fail++; $display("FAIL midreset_abandon: got %0d events want 0", wr_q.size() + dn_q.size()); end
        @(posedge clk); #1;
        model(d, l, e, n, xerr, w);
        send_line(8'h05, d, l, e, n, last_acc);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL postreset_write_count: got %0d want 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            n_cmp++; if ({wr_q[0].addr, wr_q[0].data} !== {8'h05, w}) begin n_fail++; $display("FAIL postreset_write: got %h/%h want 05/%h", wr_q[0].addr, wr_q[0].data, w); end
        end
        n_cmp++; if (dn_q.size() !== 1) begin n_fail++; $display("FAIL postreset_done_count: got %0d want 1", dn_q.size()); end
    endtask

    task automatic test_back_to_back();
        beat_arr_t da, db;
        flag_arr_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        flag_arr_t e = '{default: 1'b0};
        logic [LW-1:0] wa, wb;
        logic xerr;
        int n, acc_b, last_acc;
        for (int i = 0; i < BPL; i++) begin da[i] = $urandom; db[i] = $urandom; end
        model(da, l, e, n, xerr, wa);
        model(db, l, e, n, xerr, wb);
        clear_obs();
        sram_gnt = 1'b1;
        send_line(8'h40, da, l, e, n, last_acc);
        req_valid = 1'b1; req_addr = 8'h41;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_req_stalls: got %b want 0", req_ready); end
        do_req(8'h41, acc_b);
        n_cmp++; if (acc_b !== last_acc + 2) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_b, last_acc + 2); end
        for (int i = 0; i < n; i++) send_beat(db[i], l[i], e[i], last_acc);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 2", wr_q.size()); end
        if (wr_q.size() > 1) begin
            n_cmp++; if ({wr_q[0].addr, wr_q[0].data} !== {8'h40, wa}) begin n_fail++; $display("FAIL b2b_write0: got %h/%h want 40/%h", wr_q[0].addr, wr_q[0].data, wa); end
            n_cmp++; if ({wr_q[1].addr, wr_q[1].data} !== {8'h41, wb}) begin n_fail++; $display("FAIL b2b_write1: got %h/%h want 41/%h", wr_q[1].addr, wr_q[1].data, wb); end
        end
        if (dn_q.size() > 0) begin
            n_cmp++; if (dn_q[0].cyc !== acc_b) begin n_fail++; $display("FAIL b2b_accept_in_done_cycle: got %0d want %0d", acc_b, dn_q[0].cyc); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            beat_arr_t d;
            flag_arr_t l, e;
            logic [LW-1:0] w;
            logic [AW-1:0] a;
            logic xerr;
            int n, dly, last_acc, pos;
            a = AW'($urandom);
            pos = ($urandom_range(0, 9) < 7) ? BPL - 1 : $urandom_range(0, BPL);
            for (int i = 0; i < BPL; i++) begin
                d[i] = $urandom;
                l[i] = (i == pos);
                e[i] = ($urandom_range(0, 11) == 0);
            end
            model(d, l, e, n, xerr, w);
            dly = $urandom_range(0, 3);
            clear_obs();
            sram_gnt = (dly == 0);
            send_line(a, d, l, e, n, last_acc);
            if (dly > 0) begin
                repeat (dly) @(posedge clk);
                #1 sram_gnt = 1'b1;
            end
            repeat (4) @(posedge clk);
            #1;
            n_cmp++; if (wr_q.size() !== (xerr ? 0 : 1)) begin n_fail++; $display("FAIL rand%0d_write_count: got %0d want %0d", t, wr_q.size(), xerr ? 0 : 1); end
            if (!xerr && wr_q.size() > 0) begin
                n_cmp++; if ({wr_q[0].addr, wr_q[0].data, wr_q[0].cyc} !== {a, w, last_acc + 1 + dly}) begin
                    n_fail++; $display("FAIL rand%0d_write: got %h/%h@%0d want %h/%h@%0d", t, wr_q[0].addr, wr_q[0].data, wr_q[0].cyc, a, w, last_acc + 1 + dly);
                end
            end
            n_cmp++; if (dn_q.size() !== 1) begin n_fail++; $display("FAIL rand%0d_done_count: got %0d want 1", t, dn_q.size()); end
            if (dn_q.size() > 0) begin
                n_cmp++; if ({dn_q[0].err, dn_q[0].addr, dn_q[0].cyc} !== {xerr, a, xerr ? last_acc + 1 : last_acc + 2 + dly}) begin
                    n_fail++; $display("FAIL rand%0d_done: got %b/%h@%0d want %b/%h", t, dn_q[0].err, dn_q[0].addr, dn_q[0].cyc, xerr, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_line();
        test_grant_stall();
        test_beat_err();
        test_early_and_missing_last();
        test_reset_mid_collect();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
